ysyx_22050243_ex_alu: RTL and testbench
=======================================

// Module: ysyx_22050243_ex_alu
// PURPOSE
//  Execute-stage ALU for the RV64 core. Sits directly downstream of the ID-stage ALU-control decoder.
//  Consumes its 4-bit alu_ctrl code plus two 64-bit operands and computes the result.
//  Holds the result in one registered output slot, with valid/ready handshakes on both sides.
//  Supports back-pressure from MEM/WB and a synchronous pipeline flush.
// PARAMETERS
//  XLEN   64  datapath width (fixed 64; W-ops assume XLEN=64)
//  TAG_W  5   width of the pass-through tag (rd index)
// PORTS
//  clk        in   1      core clock, all state on rising edge
//  rst        in   1      synchronous reset, active low
//  flush      in   1      kill the held result and any same-cycle input
//  in_valid   in   1      ID presents a valid operation
//  in_ready   out  1      stage can accept this cycle
//  alu_ctrl   in   4      operation code from ALU control
//  src1       in   XLEN   operand A
//  src2       in   XLEN   operand B (register or immediate, already muxed)
//  in_tag     in   TAG_W  destination tag, carried unchanged
//  out_valid  out  1      result slot holds a valid result
//  out_ready  in   1      downstream takes the result this cycle
//  result     out  XLEN   registered ALU result
//  out_tag    out  TAG_W  registered tag
//  illegal    out  1      registered: the op had alu_ctrl==4'b1111
// BEHAVIOUR
//  Reset (rst==0 at posedge): out_valid=0, result=0, out_tag=0, illegal=0. Reset beats flush and accept.
//  in_ready = !out_valid || out_ready (combinational; no dependence on in_valid).
//  Accept: in_valid && in_ready && !flush. On accept, result/out_tag/illegal load and out_valid=1 next cycle.
//  Latency is 1 cycle. Full throughput of one op per cycle while out_ready stays high.
//  Drain without accept: out_valid && out_ready && !accept -> out_valid=0. Data registers hold their old value.
//  Stall: out_valid && !out_ready -> result, out_tag, illegal and out_valid are held stable; in_ready=0.
//  Flush: out_valid=0 next cycle. The input in that cycle is discarded, even if in_valid && in_ready.
//  Opcodes (64-bit ops use shamt src2[5:0]; W ops use src2[4:0]):
//   0000 add   src1+src2, modulo 2^64
//   1000 sub   src1-src2
//   0001 sll
//   0010 slt   signed compare, result 0 or 1
//   0011 sltu  unsigned compare, result 0 or 1
//   0100 xor
//   0101 srl
//   1101 sra
//   0110 or
//   0111 and
//   1001 addw, 1010 subw, 1011 sllw, 1100 srlw, 1110 sraw:
//        computed on src1[31:0] (srlw zero-fills, sraw sign-fills from bit31)
//        the 32-bit result is sign-extended to 64 bits
//   1111 illegal: result=0, illegal=1. The op is still handshaked normally; no stall.
//  illegal=0 for every other code.
//  Simultaneous drain+accept in one cycle: new data loads and out_valid stays 1, so no bubble.
//  Reset mid-stall drops the held result; no output is generated for it.
// TESTING
//  add: ctrl=0000, src1=5, src2=7 -> next cycle out_valid=1, result=12, out_tag=in_tag
//  subw: ctrl=1010, src1=0, src2=1 -> result=64'hFFFF_FFFF_FFFF_FFFF
//  sraw: ctrl=1110, src1=64'h0000_0000_8000_0000, src2=4 -> result=64'hFFFF_FFFF_F800_0000
//  sltu vs slt: src1=-1, src2=1 -> sltu result=0, slt result=1
//  backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, result held;
//    then out_ready=1 -> back-to-back results, no bubble
//  flush/illegal/reset: flush with accept -> out_valid=0 next cycle;
//    ctrl=1111 -> illegal=1, result=0; rst low while stalled -> all outputs 0

Source files
------------

// File: rtl/ysyx_22050243_ex_alu.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22050243_ex_alu
// Brief    : Execute-stage ALU for the RV64 core. Takes the 4-bit ALU-control
//            code and two operands from ID, computes the result, and holds it
//            in a single registered output slot with valid/ready on both sides.
//            Supports back-pressure from MEM/WB and a synchronous flush.
// Ports    : clk, rst (sync, active low)      - clock / reset
//            flush                            - kill held result and same-cycle input
//            in_valid / in_ready              - upstream handshake
//            alu_ctrl, src1, src2, in_tag     - operation, operands, dest tag
//            out_valid / out_ready            - downstream handshake
//            result, out_tag, illegal         - registered outputs
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22050243_ex_alu #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [XLEN-1:0]  src1,
    input  logic [XLEN-1:0]  src2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] out_tag,
    output logic             illegal
);

    // ------------------------------------------------------------------
    // Operation codes delivered by the ALU-control decoder
    // ------------------------------------------------------------------
    localparam logic [3:0] c_OP_ADD  = 4'b0000;
    localparam logic [3:0] c_OP_SLL  = 4'b0001;
    localparam logic [3:0] c_OP_SLT  = 4'b0010;
    localparam logic [3:0] c_OP_SLTU = 4'b0011;
    localparam logic [3:0] c_OP_XOR  = 4'b0100;
    localparam logic [3:0] c_OP_SRL  = 4'b0101;
    localparam logic [3:0] c_OP_OR   = 4'b0110;
    localparam logic [3:0] c_OP_AND  = 4'b0111;
    localparam logic [3:0] c_OP_SUB  = 4'b1000;
    localparam logic [3:0] c_OP_ADDW = 4'b1001;
    localparam logic [3:0] c_OP_SUBW = 4'b1010;
    localparam logic [3:0] c_OP_SLLW = 4'b1011;
    localparam logic [3:0] c_OP_SRLW = 4'b1100;
    localparam logic [3:0] c_OP_SRA  = 4'b1101;
    localparam logic [3:0] c_OP_SRAW = 4'b1110;
    localparam logic [3:0] c_OP_ILL  = 4'b1111;

    // ------------------------------------------------------------------
    // Output slot registers
    // ------------------------------------------------------------------
    logic             r_out_valid;
    logic [XLEN-1:0]  r_result;
    logic [TAG_W-1:0] r_out_tag;
    logic             r_illegal;

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    logic [5:0]      w_shamt;      // 64-bit ops shift by src2[5:0]
    logic [4:0]      w_shamt_w;    // W ops shift by src2[4:0]
    logic [31:0]     w_src1_lo;
    logic [31:0]     w_src2_lo;
    logic [31:0]     w_word;       // 32-bit result of W ops before sign extension
    logic            w_is_word;
    logic [XLEN-1:0] w_alu;
    logic [XLEN-1:0] w_alu_result;
    logic            w_illegal;
    logic            w_accept;

    assign w_shamt   = src2[5:0];
    assign w_shamt_w = src2[4:0];
    assign w_src1_lo = src1[31:0];
    assign w_src2_lo = src2[31:0];

    always_comb begin
        w_alu     = '0;
        w_word    = '0;
        w_is_word = 1'b0;
        w_illegal = 1'b0;
        case (alu_ctrl)
            c_OP_ADD:  w_alu = src1 + src2;
            c_OP_SUB:  w_alu = src1 - src2;
            c_OP_SLL:  w_alu = src1 << w_shamt;
            c_OP_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(src1) < $signed(src2))};
            c_OP_SLTU: w_alu = {{(XLEN-1){1'b0}}, (src1 < src2)};
            c_OP_XOR:  w_alu = src1 ^ src2;
            c_OP_SRL:  w_alu = src1 >> w_shamt;
            c_OP_SRA:  w_alu = $unsigned($signed(src1) >>> w_shamt);
            c_OP_OR:   w_alu = src1 | src2;
            c_OP_AND:  w_alu = src1 & src2;
            c_OP_ADDW: begin
                w_is_word = 1'b1;
                w_word    = w_src1_lo + w_src2_lo;
            end
            c_OP_SUBW: begin
                w_is_word = 1'b1;
                w_word    = w_src1_lo - w_src2_lo;
            end
            c_OP_SLLW: begin
                w_is_word = 1'b1;
                w_word    = w_src1_lo << w_shamt_w;
            end
            c_OP_SRLW: begin
                w_is_word = 1'b1;
                w_word    = w_src1_lo >> w_shamt_w;
            end
            c_OP_SRAW: begin
                // Sign fill comes from bit 31, not from bit 63 of src1
                w_is_word = 1'b1;
                w_word    = $unsigned($signed(w_src1_lo) >>> w_shamt_w);
            end
            c_OP_ILL:  w_illegal = 1'b1;
            default:   w_alu = '0;
        endcase
    end

    // W-op results are always sign-extended from bit 31 to the full width
    assign w_alu_result = w_is_word ? {{(XLEN-32){w_word[31]}}, w_word} : w_alu;

    // ------------------------------------------------------------------
    // Handshake: the slot can take a new op when empty or being drained
    // this cycle, so a steady stream costs no bubbles.
    // ------------------------------------------------------------------
    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready && !flush;

    // Reset beats flush, flush beats accept. Data registers only move on
    // accept; a plain drain clears valid and leaves stale data in place.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_out_tag   <= '0;
            r_illegal   <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_result    <= w_alu_result;
            r_out_tag   <= in_tag;
            r_illegal   <= w_illegal;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign out_tag   = r_out_tag;
    assign illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050243_ex_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22050243_ex_alu
// Brief    : Self-checking bench for the execute-stage ALU. A driver issues
//            directed ops and queues the hand-computed response on accept; a
//            monitor pops and compares whenever a result is handed downstream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_22050243_ex_alu;

    localparam int XLEN  = 64;
    localparam int TAG_W = 5;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_ctrl;
    logic [XLEN-1:0]  src1;
    logic [XLEN-1:0]  src2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] out_tag;
    logic             illegal;

    typedef struct {
        logic [XLEN-1:0]  res;
        logic [TAG_W-1:0] tag;
        logic             ill;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    ysyx_22050243_ex_alu #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .src1      (src1),
        .src2      (src2),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .out_tag   (out_tag),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Direct check helper
    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: inputs change just after posedge, so the negedge sees the
    // values that the next posedge will act on.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_output: got result %h tag %0d, expected nothing", result, out_tag);
                end else begin
                    e = q.pop_front();
                    n_vec++;
                    if (result !== e.res || out_tag !== e.tag || illegal !== e.ill) begin
                        n_err++;
                        $display("FAIL output: got res=%h tag=%0d ill=%b, expected res=%h tag=%0d ill=%b",
                                 result, out_tag, illegal, e.res, e.tag, e.ill);
                    end
                end
            end
        end
    end

    // Driver: hold the op until accepted, queue its expected response.
    task automatic issue(input logic [3:0] c, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [TAG_W-1:0] t, input logic [XLEN-1:0] er, input logic ei,
                         output int waited);
        bit   done;
        exp_t e;
        done     = 0;
        waited   = 0;
        alu_ctrl = c;
        src1     = a;
        src2     = b;
        in_tag   = t;
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready && !flush && rst) begin
                e.res = er;
                e.tag = t;
                e.ill = ei;
                q.push_back(e);
                done = 1;
            end
            @(posedge clk);
            #1;
            if (!done) begin
                waited++;
                if (waited > 20) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL issue_timeout: got in_ready=%b after %0d cycles, expected 1", in_ready, waited);
                    done = 1;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        alu_ctrl  = '0;
        src1      = '0;
        src2      = '0;
        in_tag    = '0;
        tick();
        tick();
        @(negedge clk);
        check("reset_out_valid", {63'b0, out_valid}, 64'd0);
        check("reset_result",    result, 64'd0);
        check("reset_out_tag",   {59'b0, out_tag}, 64'd0);
        check("reset_illegal",   {63'b0, illegal}, 64'd0);
        tick();
        rst = 1'b1;

        // ---- opcode vectors, issued back to back ----
        issue(4'b0000, 64'd5, 64'd7, 5'd3, 64'd12, 1'b0, w);
        issue(4'b1010, 64'd0, 64'd1, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, w);
        issue(4'b1110, 64'h0000_0000_8000_0000, 64'd4, 5'd5, 64'hFFFF_FFFF_F800_0000, 1'b0, w);
        issue(4'b0011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd6, 64'd0, 1'b0, w);
        issue(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd7, 64'd1, 1'b0, w);
        issue(4'b1000, 64'd3, 64'd10, 5'd8, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0, w);
        issue(4'b0001, 64'd1, 64'd63, 5'd9, 64'h8000_0000_0000_0000, 1'b0, w);
        issue(4'b0001, 64'd1, 64'd68, 5'd10, 64'd16, 1'b0, w);
        issue(4'b0101, 64'h8000_0000_0000_0000, 64'd63, 5'd11, 64'd1, 1'b0, w);
        issue(4'b1101, 64'h8000_0000_0000_0000, 64'd4, 5'd12, 64'hF800_0000_0000_0000, 1'b0, w);
        issue(4'b0100, 64'hFF00, 64'h0FF0, 5'd13, 64'hF0F0, 1'b0, w);
        issue(4'b0110, 64'hFF00, 64'h0FF0, 5'd14, 64'hFFF0, 1'b0, w);
        issue(4'b0111, 64'hFF00, 64'h0FF0, 5'd15, 64'h0F00, 1'b0, w);
        issue(4'b1001, 64'h7FFF_FFFF, 64'd1, 5'd16, 64'hFFFF_FFFF_8000_0000, 1'b0, w);
        issue(4'b1011, 64'd1, 64'd31, 5'd17, 64'hFFFF_FFFF_8000_0000, 1'b0, w);
        issue(4'b1011, 64'd1, 64'd32, 5'd18, 64'd1, 1'b0, w);
        issue(4'b1100, 64'hFFFF_FFFF_8000_0000, 64'd4, 5'd19, 64'h0000_0000_0800_0000, 1'b0, w);
        issue(4'b1111, 64'd5, 64'd7, 5'd20, 64'd0, 1'b1, w);
        check("throughput_no_wait", 64'(w), 64'd0);
        tick();
        tick();
        check("drained_queue", 64'(q.size()), 64'd0);

        // ---- back-pressure: hold A while B waits for three cycles ----
        out_ready = 1'b0;
        issue(4'b0000, 64'd100, 64'd1, 5'd21, 64'd101, 1'b0, w);
        alu_ctrl = 4'b0000; src1 = 64'd200; src2 = 64'd2; in_tag = 5'd22; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready",  {63'b0, in_ready}, 64'd0);
            check("stall_out_valid", {63'b0, out_valid}, 64'd1);
            check("stall_result",    result, 64'd101);
            tick();
        end
        out_ready = 1'b1;
        issue(4'b0000, 64'd200, 64'd2, 5'd22, 64'd202, 1'b0, w);
        check("release_accept_wait", 64'(w), 64'd0);
        issue(4'b1000, 64'd50, 64'd8, 5'd23, 64'd42, 1'b0, w);
        check("release_no_bubble_wait", 64'(w), 64'd0);
        @(negedge clk);
        check("release_out_valid", {63'b0, out_valid}, 64'd1);
        tick();
        tick();

        // ---- flush discards same-cycle input ----
        flush = 1'b1;
        alu_ctrl = 4'b0000; src1 = 64'd9; src2 = 64'd9; in_tag = 5'd24; in_valid = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_input_dropped", {63'b0, out_valid}, 64'd0);
        tick();

        // ---- flush kills a held result ----
        out_ready = 1'b0;
        issue(4'b0110, 64'h1, 64'h2, 5'd25, 64'h3, 1'b0, w);
        @(negedge clk);
        check("held_before_flush", {63'b0, out_valid}, 64'd1);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("flush_held_dropped", {63'b0, out_valid}, 64'd0);
        check("flush_queue_one", 64'(q.size()), 64'd1);
        q.delete();
        tick();

        // ---- reset while stalled drops everything ----
        issue(4'b1111, 64'd1, 64'd1, 5'd26, 64'd0, 1'b1, w);
        @(negedge clk);
        check("stall_illegal", {63'b0, illegal}, 64'd1);
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("rst_stall_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_stall_result",    result, 64'd0);
        check("rst_stall_out_tag",   {59'b0, out_tag}, 64'd0);
        check("rst_stall_illegal",   {63'b0, illegal}, 64'd0);
        q.delete();
        out_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("final_out_valid", {63'b0, out_valid}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
